// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration bundle: active-low requests, strobes and slave ready from the masters;
// active-low grants, owner index and preempt pulse back from the arbiter.
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_W        = 2
);
  logic [NUM_MASTERS-1:0] m_req_;
  logic [NUM_MASTERS-1:0] m_as_;
  logic                   bus_rdy_;
  logic [NUM_MASTERS-1:0] m_grnt_;
  logic [ID_W-1:0]        owner;
  logic                   owner_vld;
  logic                   preempt;

  modport master (output m_req_, m_as_, bus_rdy_,
                  input  m_grnt_, owner, owner_vld, preempt);
  modport slave  (input  m_req_, m_as_, bus_rdy_,
                  output m_grnt_, owner, owner_vld, preempt);
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with bounded tenure; grants registered, 1 cycle after request.
// A grant is never withdrawn while the owner has a transfer in flight (strobe seen, ready not yet).
module bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_W        = 2,
  parameter int MAX_HOLD    = 16
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWNED, RELEASE} state_t;
  localparam int TEN_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  state_t                 state;
  logic [NUM_MASTERS-1:0] grnt;
  logic [ID_W-1:0]        owner;
  logic [ID_W-1:0]        last_owner;
  logic                   owner_vld;
  logic                   preempt;
  logic                   busy;
  logic [TEN_W-1:0]       tenure;

  logic                   rr_found;
  logic [ID_W-1:0]        rr_idx;
  logic [ID_W-1:0]        cand;
  logic [NUM_MASTERS-1:0] rr_grnt;
  logic                   owner_req;
  logic                   busy_hold;
  logic                   other_req;
  logic                   hold_expired;

  // Search starts just after the last owner, so it is naturally considered last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = ID_W'((int'(last_owner) + i) % NUM_MASTERS);
      if (!rr_found && !bus.m_req_[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign rr_grnt      = ~(NUM_MASTERS'(1) << rr_idx);
  assign owner_req    = ~bus.m_req_[owner];
  // A strobe arriving this cycle also pins the grant, not just the registered flag.
  assign busy_hold    = busy | (~bus.m_as_[owner] & bus.bus_rdy_);
  assign other_req    = |(~bus.m_req_ & ~(NUM_MASTERS'(1) << owner));
  assign hold_expired = (MAX_HOLD != 0) && (int'(tenure) >= MAX_HOLD - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grnt       <= '1;
      owner      <= '0;
      owner_vld  <= 1'b0;
      preempt    <= 1'b0;
      busy       <= 1'b0;
      tenure     <= '0;
      last_owner <= ID_W'(NUM_MASTERS - 1);
    end else begin
      preempt <= 1'b0;
      case (state)
        OWNED: begin
          if (MAX_HOLD != 0 && int'(tenure) < MAX_HOLD) tenure <= tenure + 1'b1;
          if (!bus.bus_rdy_)             busy <= 1'b0;
          else if (!bus.m_as_[owner])    busy <= 1'b1;
          if (!owner_req && !busy_hold) begin
            if (rr_found) begin
              state      <= OWNED;
              grnt       <= rr_grnt;
              owner      <= rr_idx;
              owner_vld  <= 1'b1;
              last_owner <= rr_idx;
              tenure     <= '0;
              busy       <= 1'b0;
            end else begin
              state     <= IDLE;
              grnt      <= '1;
              owner_vld <= 1'b0;
              busy      <= 1'b0;
            end
          end else if (hold_expired && other_req && !busy_hold) begin
            state     <= RELEASE;
            grnt      <= '1;
            owner_vld <= 1'b0;
            preempt   <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
          if (rr_found) begin
            state      <= OWNED;
            grnt       <= rr_grnt;
            owner      <= rr_idx;
            owner_vld  <= 1'b1;
            last_owner <= rr_idx;
            tenure     <= '0;
          end else begin
            state     <= IDLE;
            grnt      <= '1;
            owner_vld <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.m_grnt_   = grnt;
  assign bus.owner     = owner;
  assign bus.owner_vld = owner_vld;
  assign bus.preempt   = preempt;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios push time-stamped expected output changes,
// a negedge monitor pops and compares every observed change of grant/owner state or preempt pulse.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   mon_en = 1'b0;

  bus_arbiter_if #(.NUM_MASTERS(4), .ID_W(2)) bus ();

  bus_arbiter #(.NUM_MASTERS(4), .ID_W(2), .MAX_HOLD(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] grnt;
    logic       vld;
    logic [1:0] own;
    logic       pre;
    string      name;
  } ev_t;

  ev_t sb[$];

  logic [3:0] prev_grnt = 4'hF;
  logic       prev_vld  = 1'b0;
  logic [1:0] prev_own  = 2'd0;
  logic [1:0] own_now;
  ev_t        mon_e;

  always @(negedge clk) begin
    own_now = bus.owner_vld ? bus.owner : 2'd0;
    if (mon_en && (bus.m_grnt_ != prev_grnt || bus.owner_vld != prev_vld ||
                   own_now != prev_own || bus.preempt)) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: got cyc=%0d grnt=%b vld=%b owner=%0d preempt=%b, required no output change",
                 cyc, bus.m_grnt_, bus.owner_vld, own_now, bus.preempt);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.at != cyc || mon_e.grnt !== bus.m_grnt_ || mon_e.vld !== bus.owner_vld ||
            mon_e.own !== own_now || mon_e.pre !== bus.preempt) begin
          mismatched++;
          $display("FAIL %s: got cyc=%0d grnt=%b vld=%b owner=%0d preempt=%b, required cyc=%0d grnt=%b vld=%b owner=%0d preempt=%b",
                   mon_e.name, cyc, bus.m_grnt_, bus.owner_vld, own_now, bus.preempt,
                   mon_e.at, mon_e.grnt, mon_e.vld, mon_e.own, mon_e.pre);
        end
      end
    end
    prev_grnt = bus.m_grnt_;
    prev_vld  = bus.owner_vld;
    prev_own  = own_now;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int at, input logic [3:0] g, input logic v,
                           input logic [1:0] o, input logic p, input string nm);
    ev_t e;
    e.at = at; e.grnt = g; e.vld = v; e.own = o; e.pre = p; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] req);
    compared++;
    if (got !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  // Asserts reset between edges and checks outputs before the next edge arrives.
  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("rst_grnt",    8'(bus.m_grnt_),   8'h0F);
    check("rst_vld",     8'(bus.owner_vld), 8'h00);
    check("rst_owner",   8'(bus.owner),     8'h00);
    check("rst_preempt", 8'(bus.preempt),   8'h00);
    tick();
    reset  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending events, required 0", sb.size());
      sb.delete();
    end
    tick(2);
  endtask

  initial begin
    int         c;
    int         o;
    int         nx;
    logic [3:0] g;

    reset        = 1'b0;
    bus.m_req_   = 4'hF;
    bus.m_as_    = 4'hF;
    bus.bus_rdy_ = 1'b1;
    tick();

    // Single request from master 0, then drop
    do_reset();
    c = cyc;
    bus.m_req_ = 4'b1110;
    expect_ev(c + 1, 4'b1110, 1'b1, 2'd0, 1'b0, "s1_grant0");
    tick();
    bus.m_req_ = 4'hF;
    expect_ev(c + 2, 4'hF, 1'b0, 2'd0, 1'b0, "s1_idle");
    drain();

    // All request; each owner does one transfer then releases: 0,1,2,3,0 back-to-back
    do_reset();
    c = cyc;
    bus.m_req_ = 4'b0000;
    expect_ev(c + 1, 4'b1110, 1'b1, 2'd0, 1'b0, "s2_grant0");
    tick();
    for (int k = 0; k < 5; k++) begin
      o = k % 4;
      bus.m_req_ = 4'b0000;
      g = 4'b0001 << o;
      bus.m_as_ = ~g;
      tick();
      bus.m_as_    = 4'hF;
      bus.bus_rdy_ = 1'b0;
      tick();
      bus.bus_rdy_ = 1'b1;
      c = cyc;
      if (k < 4) begin
        bus.m_req_ = g;
        nx = (o + 1) % 4;
        g = 4'b0001 << nx;
        expect_ev(c + 1, ~g, 1'b1, 2'(nx), 1'b0, "s2_handover");
      end else begin
        bus.m_req_ = 4'hF;
        expect_ev(c + 1, 4'hF, 1'b0, 2'd0, 1'b0, "s2_idle");
      end
      tick();
    end
    drain();

    // Master 1 holds without transfers; master 2 requests late -> preempt at tenure 15
    do_reset();
    c = cyc;
    bus.m_req_ = 4'b1101;
    expect_ev(c + 1,  4'b1101, 1'b1, 2'd1, 1'b0, "s3_grant1");
    expect_ev(c + 17, 4'hF,    1'b0, 2'd0, 1'b1, "s3_preempt");
    expect_ev(c + 18, 4'b1011, 1'b1, 2'd2, 1'b0, "s3_grant2");
    tick(5);
    bus.m_req_ = 4'b1001;
    tick(14);
    bus.m_req_ = 4'hF;
    expect_ev(c + 20, 4'hF, 1'b0, 2'd0, 1'b0, "s3_idle");
    drain();

    // As above but a transfer in flight across the limit delays the preempt
    do_reset();
    c = cyc;
    bus.m_req_ = 4'b1101;
    expect_ev(c + 1,  4'b1101, 1'b1, 2'd1, 1'b0, "s4_grant1");
    expect_ev(c + 23, 4'hF,    1'b0, 2'd0, 1'b1, "s4_preempt");
    expect_ev(c + 24, 4'b1011, 1'b1, 2'd2, 1'b0, "s4_grant2");
    tick(5);
    bus.m_req_ = 4'b1001;
    tick(10);
    bus.m_as_ = 4'b1101;
    tick();
    bus.m_as_ = 4'hF;
    tick(5);
    bus.bus_rdy_ = 1'b0;
    tick();
    bus.bus_rdy_ = 1'b1;
    tick(3);
    bus.m_req_ = 4'hF;
    expect_ev(c + 26, 4'hF, 1'b0, 2'd0, 1'b0, "s4_idle");
    drain();

    // Owner drops its request mid-transfer; grant held until ready, then master 3
    do_reset();
    c = cyc;
    bus.m_req_ = 4'b1110;
    expect_ev(c + 1, 4'b1110, 1'b1, 2'd0, 1'b0, "s5_grant0");
    expect_ev(c + 6, 4'b0111, 1'b1, 2'd3, 1'b0, "s5_grant3");
    tick();
    bus.m_as_  = 4'b1110;
    bus.m_req_ = 4'b0110;
    tick();
    bus.m_as_  = 4'hF;
    bus.m_req_ = 4'b0111;
    tick(2);
    bus.bus_rdy_ = 1'b0;
    tick();
    bus.bus_rdy_ = 1'b1;
    tick();
    bus.m_req_ = 4'hF;
    expect_ev(c + 7, 4'hF, 1'b0, 2'd0, 1'b0, "s5_idle");
    drain();

    // Reset during a transfer by master 2; afterwards master 0 wins first
    do_reset();
    c = cyc;
    bus.m_req_ = 4'b1011;
    expect_ev(c + 1, 4'b1011, 1'b1, 2'd2, 1'b0, "s6_grant2");
    tick();
    bus.m_req_ = 4'b0000;
    bus.m_as_  = 4'b1011;
    tick();
    bus.m_as_  = 4'hF;
    tick();
    do_reset();
    c = cyc;
    expect_ev(c + 1, 4'b1110, 1'b1, 2'd0, 1'b0, "s6_grant0_after_reset");
    tick();
    bus.m_req_ = 4'hF;
    expect_ev(c + 2, 4'hF, 1'b0, 2'd0, 1'b0, "s6_idle");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
